// File: rtl/gb_rd_ctrl_mc_if.sv
// Global-buffer read port bundle: SRAM read request/pointer toward the banks and
// PE data-valid/ready handshake, one lane per channel.
interface gb_rd_ctrl_mc_if #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 9,
  parameter int ID_W       = 6
);
  logic [NUM_CH-1:0]            rd_en;
  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_CH*ID_W-1:0]       rd_id;
  logic [NUM_CH*ID_W-1:0]       next_id;
  logic [NUM_CH-1:0]            pe_val;
  logic [NUM_CH-1:0]            pe_rdy;

  modport master (
    output rd_en, rd_addr, rd_id, next_id, pe_val,
    input  pe_rdy
  );

  modport slave (
    input  rd_en, rd_addr, rd_id, next_id, pe_val,
    output pe_rdy
  );
endinterface

// File: rtl/gb_rd_ctrl_mc.sv
// Multi-channel GB read controller: per-channel pass/word sequencing, bank pointer
// with pull-back replay, and PE valid generation with one-cycle SRAM latency.
module gb_rd_ctrl_mc #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 9,
  parameter int CYC_W      = 12,
  parameter int NUM_W      = 4,
  parameter int ID_W       = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_CH*NUM_W-1:0]          cfg_sram_num,
  input  logic [NUM_CH*ADDR_WIDTH+NUM_CH-1:0] cfg_word_num,
  input  logic [NUM_CH*CYC_W-1:0]          cfg_cyc_num,
  input  logic [NUM_CH-1:0]                rd_prepare,
  input  logic [NUM_CH-1:0]                pullback,
  gb_rd_ctrl_mc_if.master                  rd_if,
  output logic [NUM_CH-1:0]                pass_done,
  output logic [NUM_CH-1:0]                rd_done,
  output logic [NUM_CH*2-1:0]              state,
  output logic [NUM_CH*CYC_W-1:0]          pass_cnt
);

  localparam int WW  = ADDR_WIDTH + 1;
  localparam int NW1 = NUM_W + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_READ = 2'd2, S_DONE = 2'd3} st_e;

  logic [NUM_W-1:0] sram_q [NUM_CH];
  logic [WW-1:0]    word_q [NUM_CH];
  logic [CYC_W-1:0] cyc_q  [NUM_CH];

  // Bank count 0 is stored as 1 so base IDs and the wrap rule see the effective size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        sram_q[c] <= '0;
        word_q[c] <= '0;
        cyc_q[c]  <= '0;
      end
    end else if (start) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        sram_q[c] <= (cfg_sram_num[c*NUM_W +: NUM_W] == '0) ? NUM_W'(1)
                                                            : cfg_sram_num[c*NUM_W +: NUM_W];
        word_q[c] <= cfg_word_num[c*WW +: WW];
        cyc_q[c]  <= cfg_cyc_num[c*CYC_W +: CYC_W];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    st_e                   st_q;
    logic [ADDR_WIDTH-1:0] addr_q, saddr_q, addr_nx;
    logic [NUM_W-1:0]      rel_q, srel_q, rel_inc, rel_nx;
    logic [WW-1:0]         wcnt_q;
    logic [CYC_W-1:0]      pcnt_q;
    logic                  pdone_q, pval_q, ren;
    logic [ID_W-1:0]       base;
    logic [WW-1:0]         wnum_in;
    logic [CYC_W-1:0]      cnum_in;

    assign wnum_in = cfg_word_num[c*WW +: WW];
    assign cnum_in = cfg_cyc_num[c*CYC_W +: CYC_W];

    always_comb begin
      base = '0;
      for (int unsigned k = 0; k < c; k++) base = base + ID_W'(sram_q[k]);
    end

    // The >= form also covers the post-reset bank count of 0.
    assign rel_inc = (({1'b0, rel_q} + NW1'(1)) >= {1'b0, sram_q[c]}) ? '0 : rel_q + NUM_W'(1);
    assign addr_nx = addr_q + ADDR_WIDTH'(1);
    assign rel_nx  = (addr_q == '1) ? rel_inc : rel_q;
    assign ren     = (st_q == S_READ) && rd_if.pe_rdy[c];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q    <= S_IDLE;
        addr_q  <= '0;
        saddr_q <= '0;
        rel_q   <= '0;
        srel_q  <= '0;
        wcnt_q  <= '0;
        pcnt_q  <= '0;
        pdone_q <= 1'b0;
        pval_q  <= 1'b0;
      end else begin
        pdone_q <= 1'b0;
        pval_q  <= ren;
        if (start) begin
          st_q    <= (wnum_in == '0 || cnum_in == '0) ? S_DONE : S_WAIT;
          addr_q  <= '0;
          saddr_q <= '0;
          rel_q   <= '0;
          srel_q  <= '0;
          wcnt_q  <= '0;
          pcnt_q  <= '0;
        end else begin
          case (st_q)
            S_WAIT: if (rd_prepare[c]) begin
              st_q    <= S_READ;
              saddr_q <= addr_q;
              srel_q  <= rel_q;
            end
            S_READ: if (ren) begin
              if (wcnt_q == word_q[c] - WW'(1)) begin
                pdone_q <= 1'b1;
                pcnt_q  <= pcnt_q + CYC_W'(1);
                wcnt_q  <= '0;
                st_q    <= (pcnt_q + CYC_W'(1) == cyc_q[c]) ? S_DONE : S_WAIT;
                addr_q  <= pullback[c] ? saddr_q : addr_nx;
                rel_q   <= pullback[c] ? srel_q  : rel_nx;
              end else begin
                wcnt_q <= wcnt_q + WW'(1);
                addr_q <= addr_nx;
                rel_q  <= rel_nx;
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign rd_if.rd_en[c]                          = ren;
    assign rd_if.pe_val[c]                         = pval_q;
    assign rd_if.rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
    assign rd_if.rd_id[c*ID_W +: ID_W]             = base + ID_W'(rel_q);
    assign rd_if.next_id[c*ID_W +: ID_W]           = base + ID_W'(rel_inc);
    assign pass_done[c]                            = pdone_q;
    assign rd_done[c]                              = (st_q == S_DONE);
    assign state[c*2 +: 2]                         = st_q;
    assign pass_cnt[c*CYC_W +: CYC_W]              = pcnt_q;
  end

endmodule

// File: tb/tb_gb_rd_ctrl_mc.sv
// Directed bench for gb_rd_ctrl_mc: reset, pass/pull-back sequencing, bank ID
// walk across channels, ready toggling, mid-pass restart and zero-pass config.
module tb_gb_rd_ctrl_mc;
  localparam int NC = 3;
  localparam int AW = 9;
  localparam int CW = 12;
  localparam int NW = 4;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [NC*NW-1:0]     cfg_sram_num;
  logic [NC*(AW+1)-1:0] cfg_word_num;
  logic [NC*CW-1:0]     cfg_cyc_num;
  logic [NC-1:0]        rd_prepare, pullback, pass_done, rd_done;
  logic [NC*2-1:0]      state;
  logic [NC*CW-1:0]     pass_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gb_rd_ctrl_mc_if #(.NUM_CH(NC), .ADDR_WIDTH(AW), .ID_W(IW)) rdif ();

  gb_rd_ctrl_mc #(.NUM_CH(NC), .ADDR_WIDTH(AW), .CYC_W(CW), .NUM_W(NW), .ID_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_sram_num (cfg_sram_num),
    .cfg_word_num (cfg_word_num),
    .cfg_cyc_num  (cfg_cyc_num),
    .rd_prepare   (rd_prepare),
    .pullback     (pullback),
    .rd_if        (rdif.master),
    .pass_done    (pass_done),
    .rd_done      (rd_done),
    .state        (state),
    .pass_cnt     (pass_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] f_addr(input int c);
    return 64'(rdif.rd_addr[c*AW +: AW]);
  endfunction
  function automatic logic [63:0] f_id(input int c);
    return 64'(rdif.rd_id[c*IW +: IW]);
  endfunction
  function automatic logic [63:0] f_nid(input int c);
    return 64'(rdif.next_id[c*IW +: IW]);
  endfunction
  function automatic logic [63:0] f_st(input int c);
    return 64'(state[c*2 +: 2]);
  endfunction
  function automatic logic [63:0] f_pc(input int c);
    return 64'(pass_cnt[c*CW +: CW]);
  endfunction

  task automatic set_cfg(input int c, input int s, input int w, input int y);
    cfg_sram_num[c*NW +: NW]         = NW'(s);
    cfg_word_num[c*(AW+1) +: (AW+1)] = (AW+1)'(w);
    cfg_cyc_num[c*CW +: CW]          = CW'(y);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pstart [3];
    int pend [3];
    pstart = '{0, 0, 4};
    pend   = '{0, 4, 8};
    cfg_sram_num = '0;
    cfg_word_num = '0;
    cfg_cyc_num  = '0;
    rd_prepare   = '0;
    pullback     = '0;
    rdif.pe_rdy  = 3'b111;

    // Reset values
    repeat (3) tick();
    chk("rst_state", 64'(state), 0);
    chk("rst_rd_en", 64'(rdif.rd_en), 0);
    chk("rst_pe_val", 64'(rdif.pe_val), 0);
    chk("rst_addr", 64'(rdif.rd_addr), 0);
    chk("rst_rd_id", 64'(rdif.rd_id), 0);
    chk("rst_next_id", 64'(rdif.next_id), 0);
    chk("rst_pass_done", 64'(pass_done), 0);
    chk("rst_rd_done", 64'(rd_done), 0);
    chk("rst_pass_cnt", 64'(pass_cnt), 0);
    rst = 1'b0;
    tick();

    // Ch0: 4 words x 3 passes, pull-back on the first pass; ch1/ch2 zero passes
    set_cfg(0, 2, 4, 3);
    set_cfg(1, 1, 100, 0);
    set_cfg(2, 3, 5, 0);
    rdif.pe_rdy = 3'b000;
    do_start();
    chk("A_state_after_start", 64'(state), 64'(6'b11_11_01));
    chk("A_rd_done", 64'(rd_done), 3'b110);
    chk("A_id0", f_id(0), 0);
    chk("A_id1", f_id(1), 2);
    chk("A_id2", f_id(2), 3);
    chk("A_nid0", f_nid(0), 1);
    chk("A_nid1", f_nid(1), 2);
    chk("A_nid2", f_nid(2), 4);
    rdif.pe_rdy = 3'b111;
    #1;
    chk("A_rd_en_wait", 64'(rdif.rd_en), 0);
    rd_prepare = 3'b001;
    pullback   = 3'b001;
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 4; w++) begin
        tick();
        chk("A_state", f_st(0), 2);
        chk("A_rd_en", 64'(rdif.rd_en), 3'b001);
        chk("A_addr", f_addr(0), 64'(pstart[p] + w));
        chk("A_pe_val", 64'(rdif.pe_val[0]), 64'(w > 0));
        chk("A_no_pass_done", 64'(pass_done), 0);
      end
      tick();
      if (p == 0) pullback = 3'b000;
      chk("A_pass_done", 64'(pass_done), 3'b001);
      chk("A_pass_cnt", f_pc(0), 64'(p + 1));
      chk("A_state_end", f_st(0), (p == 2) ? 3 : 1);
      chk("A_addr_end", f_addr(0), 64'(pend[p]));
      chk("A_pe_val_end", 64'(rdif.pe_val[0]), 1);
    end
    tick();
    chk("A_pulse_width", 64'(pass_done), 0);
    chk("A_all_done", 64'(rd_done), 3'b111);
    chk("A_no_rd_en_done", 64'(rdif.rd_en), 0);

    // Ch1: pe_rdy toggling 1010..., then restart mid-pass at address 37
    set_cfg(0, 2, 4, 0);
    set_cfg(1, 1, 20, 3);
    set_cfg(2, 3, 5, 0);
    rd_prepare  = 3'b010;
    rdif.pe_rdy = 3'b000;
    do_start();
    chk("C_state_wait", f_st(1), 1);
    for (int i = 0; i <= 74; i++) begin
      tick();
      rdif.pe_rdy = (i % 2 == 0) ? 3'b010 : 3'b000;
      #1;
      chk("C_rd_en", 64'(rdif.rd_en[1]), 64'(i % 2 == 0));
      chk("C_pe_val", 64'(rdif.pe_val[1]), 64'(i % 2));
      chk("C_addr", f_addr(1), 64'((i + 1) / 2));
      chk("C_state", f_st(1), (i == 39) ? 1 : 2);
      chk("C_pass_done", 64'(pass_done[1]), 64'(i == 39));
      chk("C_pass_cnt", f_pc(1), 64'(i >= 39));
    end
    chk("C_addr_37", f_addr(1), 37);
    do_start();
    chk("C_restart_state", f_st(1), 1);
    chk("C_restart_addr", f_addr(1), 0);
    chk("C_restart_pass_cnt", f_pc(1), 0);
    chk("C_inflight_pe_val", 64'(rdif.pe_val[1]), 1);
    chk("C_restart_id", f_id(1), 2);
    tick();
    chk("C_resume_state", f_st(1), 2);
    chk("C_resume_addr", f_addr(1), 0);
    chk("C_resume_rd_en", 64'(rdif.rd_en[1]), 1);
    chk("C_resume_pe_val", 64'(rdif.pe_val[1]), 0);
    tick();
    chk("C_resume_addr1", f_addr(1), 1);

    // Ch2: 3 banks at base 3, 3 passes x 343 words = 2*512+5 reads
    set_cfg(0, 2, 4, 0);
    set_cfg(1, 1, 20, 0);
    set_cfg(2, 3, 343, 3);
    rd_prepare  = 3'b100;
    rdif.pe_rdy = 3'b100;
    do_start();
    for (int i = 0; i <= 1031; i++) begin
      tick();
      if (i == 0) begin
        chk("D_addr_c0", f_addr(2), 0);
        chk("D_id_c0", f_id(2), 3);
        chk("D_nid_c0", f_nid(2), 4);
      end
      if (i == 343) begin
        chk("D_pd_p0", 64'(pass_done[2]), 1);
        chk("D_st_p0", f_st(2), 1);
        chk("D_addr_p0", f_addr(2), 343);
      end
      if (i == 512) begin
        chk("D_addr_511", f_addr(2), 511);
        chk("D_id_511", f_id(2), 3);
        chk("D_nid_511", f_nid(2), 4);
      end
      if (i == 513) begin
        chk("D_addr_512", f_addr(2), 0);
        chk("D_id_512", f_id(2), 4);
        chk("D_nid_512", f_nid(2), 5);
      end
      if (i == 687) begin
        chk("D_pd_p1", 64'(pass_done[2]), 1);
        chk("D_pc_p1", f_pc(2), 2);
        chk("D_addr_p1", f_addr(2), 174);
        chk("D_id_p1", f_id(2), 4);
      end
      if (i == 1026) begin
        chk("D_addr_1024", f_addr(2), 0);
        chk("D_id_1024", f_id(2), 5);
        chk("D_nid_wrap", f_nid(2), 3);
      end
      if (i == 1030) begin
        chk("D_addr_last", f_addr(2), 4);
        chk("D_st_last", f_st(2), 2);
        chk("D_pd_last", 64'(pass_done[2]), 0);
      end
      if (i == 1031) begin
        chk("D_st_done", f_st(2), 3);
        chk("D_pd_done", 64'(pass_done[2]), 1);
        chk("D_pc_done", f_pc(2), 3);
        chk("D_rd_done", 64'(rd_done), 3'b111);
        chk("D_addr_done", f_addr(2), 5);
        chk("D_id_done", f_id(2), 5);
        chk("D_no_rd_en", 64'(rdif.rd_en), 0);
      end
    end

    // Reset while reading, then restart latency
    do_start();
    repeat (3) tick();
    chk("E_addr_pre", f_addr(2), 2);
    rst = 1'b1;
    #1;
    chk("E_state", 64'(state), 0);
    chk("E_rd_en", 64'(rdif.rd_en), 0);
    chk("E_pe_val", 64'(rdif.pe_val), 0);
    chk("E_addr", 64'(rdif.rd_addr), 0);
    chk("E_rd_id", 64'(rdif.rd_id), 0);
    chk("E_next_id", 64'(rdif.next_id), 0);
    chk("E_pass_cnt", 64'(pass_cnt), 0);
    chk("E_rd_done", 64'(rd_done), 0);
    tick();
    rst = 1'b0;
    tick();
    do_start();
    chk("E_start_rd_en", 64'(rdif.rd_en[2]), 0);
    chk("E_start_state", f_st(2), 1);
    tick();
    chk("E_first_rd_en", 64'(rdif.rd_en[2]), 1);
    chk("E_first_addr", f_addr(2), 0);
    chk("E_first_id", f_id(2), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
